// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: scan chain shift-in / capture / shift-out sequencer.
// Optional unload signature register enabled by defining SCAN_MISR_EN.
module scan_chain_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CAPTURE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             func_en,
  input  logic             sd_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             sd_out,
  output logic             se,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sig
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   bitCnt;
  logic [WIDTH-1:0] shiftVal;
  logic [WIDTH-1:0] capVal;
  logic            lastBit;

  assign shiftVal = {q[WIDTH-2:0], sd_in};
  assign capVal   = (CAPTURE_MODE == 1) ? {~q[WIDTH-2:0], d_in[0]} : d_in;
  assign lastBit  = bitCnt == CW'(WIDTH - 1);
  assign sd_out   = q[WIDTH-1];

  // se/busy/done are registered alongside the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bitCnt <= '0;
      q      <= '0;
      se     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SHIFT_IN;
            bitCnt <= '0;
            se     <= 1'b1;
            busy   <= 1'b1;
          end else if (func_en) begin
            q <= capVal;
          end
        end
        SHIFT_IN: begin
          q      <= shiftVal;
          bitCnt <= bitCnt + 1'b1;
          if (lastBit) begin
            state <= CAPTURE;
            se    <= 1'b0;
          end
        end
        CAPTURE: begin
          q      <= capVal;
          state  <= SHIFT_OUT;
          bitCnt <= '0;
          se     <= 1'b1;
        end
        SHIFT_OUT: begin
          q      <= shiftVal;
          bitCnt <= bitCnt + 1'b1;
          if (lastBit) begin
            state <= DONE;
            se    <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          se    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCAN_MISR_EN
  // rotate-and-fold of the pre-shift serial output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig <= '0;
    else if (state == IDLE && start)
      sig <= '0;
    else if (state == SHIFT_OUT)
      sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ {{(WIDTH-1){1'b0}}, sd_out};
  end
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed checks of scan_chain_ctrl at WIDTH=8, both capture modes.
module tb_scan_chain_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       func_en = 1'b0;
  logic       sd_in = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] q0, q1, sig0, sig1;
  logic       sdOut0, sdOut1, se0, se1, busy0, busy1, done0, done1;
  int         nChecks = 0;
  int         nPass = 0;
  logic [7:0] expSig;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.WIDTH(8), .CAPTURE_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .func_en(func_en), .sd_in(sd_in),
    .d_in(d_in), .q(q0), .sd_out(sdOut0), .se(se0), .busy(busy0), .done(done0), .sig(sig0)
  );

  scan_chain_ctrl #(.WIDTH(8), .CAPTURE_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .func_en(func_en), .sd_in(sd_in),
    .d_in(d_in), .q(q1), .sd_out(sdOut1), .se(se1), .busy(busy1), .done(done1), .sig(sig1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence with sd_in=0, pulsing start mid-SHIFT_IN and in DONE.
  task automatic runSeq(input string tag);
    int busyCnt, doneCnt, doneAt;
    busyCnt = 0; doneCnt = 0; doneAt = 0;
    start = 1'b1; sd_in = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!busy0) break;
      busyCnt++;
      if (done0) begin doneCnt++; doneAt = k; end
      start = (k == 3 || k == 18);
      tick();
    end
    start = 1'b0;
    check({tag, "_busyCycles"}, busyCnt, 18);
    check({tag, "_doneAt"}, doneAt, 18);
    check({tag, "_doneCount"}, doneCnt, 1);
    tick();
    check({tag, "_idleAfter"}, busy0, 0);
  endtask

  initial begin
    logic [7:0] inBits, capBits;
    inBits = 8'hB2; capBits = 8'hA5;
`ifdef SCAN_MISR_EN
    expSig = 8'hA5;
`else
    expSig = 8'h00;
`endif
    repeat (3) tick();
    check("rst_q", q0, 8'h00);
    check("rst_sdout", sdOut0, 0);
    check("rst_se", se0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_sig", sig0, 8'h00);
    rst_n = 1'b1;
    tick();

    // shift-in B2 then mode-0 capture of A5
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sd_in = inBits[7-i];
      check("shin_se", se0, 1);
      check("shin_busy", busy0, 1);
      tick();
    end
    check("capture_entry_q", q0, 8'hB2);
    check("capture_se", se0, 0);
    d_in = capBits;
    sd_in = 1'b0;
    tick();
    check("mode0_cap_q", q0, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      check("shout_sdout", sdOut0, capBits[7-i]);
      check("shout_se", se0, 1);
      check("shout_done", done0, 0);
      tick();
    end
    check("done_pulse", done0, 1);
    check("done_busy", busy0, 1);
    check("done_sig", sig0, expSig);
    tick();
    check("done_cleared", done0, 0);
    check("idle_busy", busy0, 0);
    check("idle_sig_hold", sig0, expSig);

    // mode 1: shift in all ones, capture with d_in[0]=1
    start = 1'b1;
    tick();
    start = 1'b0;
    sd_in = 1'b1;
    repeat (8) tick();
    check("mode1_pre_q", q1, 8'hFF);
    d_in = 8'h01;
    sd_in = 1'b0;
    tick();
    check("mode1_cap_q", q1, 8'h01);
    for (int k = 0; k < 20 && busy1; k++) tick();
    check("mode1_idle", busy1, 0);
    check("mode1_zero_q", q1, 8'h00);
    d_in = 8'h00;
    func_en = 1'b1;
    tick();
    check("mode1_func_q", q1, 8'hFE);
    check("mode0_func_q", q0, 8'h00);
    func_en = 1'b0;
    d_in = 8'h3C;
    tick();
    check("func_hold_q", q0, 8'h00);

    // protocol: restart ignored, abort by reset, full sequence after release
    runSeq("seq1");
    start = 1'b1;
    tick();
    start = 1'b0;
    sd_in = 1'b1;
    repeat (12) tick();
    check("abort_pre_se", se0, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_q", q0, 8'h00);
    check("abort_done", done0, 0);
    check("abort_se", se0, 0);
    #1 rst_n = 1'b1;
    sd_in = 1'b0;
    repeat (3) begin
      tick();
      check("abort_nodone", done0, 0);
    end
    runSeq("seq2");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
